value_predict_table: RTL and testbench
======================================

Name: value_predict_table

Overview:
PC-indexed, direct-mapped load-value predictor table that sits directly upstream of value_prediction.
- On a load lookup, returns a registered predicted value and a confidence flag. The downstream stage speculates only when the flag is set.
- Retired load data trains the table through the update port.
- Tag/valid/last-value/stride/confidence are held per entry. A clear-sweep FSM invalidates all entries after reset or flush.

Parameters:
INDEX_WIDTH, 6, log2 of entry count (64 entries)
CONF_WIDTH, 2, width of saturating confidence counter
CONF_THRESH, 2, confidence value at or above which pred_confident asserts

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-high reset (asserted = reset)
flush  input  1  invalidate whole table (pipeline/context flush)
ready  output  1  table usable; 0 during clear sweep
lookup_valid  input  1  lookup request this cycle
lookup_pc  input  `ADDR_WIDTH  PC of load being predicted
pred_valid  output  1  prediction result valid (1 cycle after lookup_valid)
pred_value  output  `DATA_WIDTH  predicted load data
pred_confident  output  1  confidence >= CONF_THRESH and tag hit
update_valid  input  1  train with retired load
update_pc  input  `ADDR_WIDTH  PC of retired load
update_value  input  `DATA_WIDTH  actual loaded data

Behaviour:
- Address split: index = pc[INDEX_WIDTH+1:2]; tag = pc[`ADDR_WIDTH-1:INDEX_WIDTH+2].
- Reset (async, rst_n=1):
  - Outputs: pred_valid=0, pred_value=0, pred_confident=0, ready=0.
  - FSM: state=CLEAR, clr_idx=0.
  - The data array (tag/last/stride/conf) has no reset. Only the valid bits are cleared, by the sweep.
- FSM:
  - CLEAR: clears valid[clr_idx] each cycle and increments clr_idx. When clr_idx == 2^INDEX_WIDTH-1, it clears that entry and moves to IDLE. A full sweep is 2^INDEX_WIDTH cycles.
  - IDLE: ready=1. flush=1 moves to CLEAR with clr_idx=0.
  - flush during CLEAR restarts clr_idx at 0.
  - ready is a registered decode of state: 1 only in IDLE.
- Lookup (latency 1, registered outputs):
  - pred_valid is always the registered copy of lookup_valid.
  - Not ready or tag miss: pred_value=0, pred_confident=0.
  - Hit: pred_value = predicted(entry); pred_confident = (conf >= CONF_THRESH).
  - When lookup_valid=0 on the previous edge: pred_valid=0; pred_value and pred_confident = 0.
- Update (in IDLE only; ignored in CLEAR, including the cycle flush is asserted):
  - Miss (invalid or tag mismatch): allocate. valid=1, tag, last=update_value, stride=0, conf=0.
  - Hit and update_value == predicted(entry): conf = min(conf+1, 2^CONF_WIDTH-1).
  - Hit and mismatch: conf=0.
  - On every hit: stride = update_value - last (mod 2^`DATA_WIDTH, wraps); last = update_value.
- predicted(entry) = last + stride (mod 2^`DATA_WIDTH) with VP_STRIDE_EN; otherwise last.
- Same-cycle lookup and update to the same index: lookup reads pre-update contents (read-before-write, no bypass).

Optional Feature:
VP_STRIDE_EN
- Defined: per-entry stride field present; prediction = last + stride; training compares against last + stride.
- Undefined: no stride storage; last-value predictor; prediction = last; training compares against last.

Decomposition:
- Shared package (mips_core_pkg):
  - vp_entry_t struct: valid, tag, last, stride (under VP_STRIDE_EN), conf.
  - vp_state_t enum: CLEAR, IDLE.
  - Index/tag width localparams derived from `ADDR_WIDTH and INDEX_WIDTH.
- Sub-module: vp_conf_counter (saturating CONF_WIDTH up/clear counter), used in the update path.
- Table array and FSM stay in value_predict_table.

Test Plan:
- Reset released -> ready=0 for 64 cycles, then 1. Lookup pc 0x100 the next cycle -> pred_valid=1, pred_confident=0, pred_value=0.
- Last-value training: update pc 0x100 value 0x5 three times, then lookup 0x100 -> pred_value=0x5, pred_confident=1 (conf=2). Holds both with and without VP_STRIDE_EN.
- Stride training (VP_STRIDE_EN): updates pc 0x104 with 10, 20, 30, 40, then lookup -> pred_value=50, pred_confident=1. Without the macro -> pred_value=40, pred_confident=0.
- Conflict and mispredict:
  - Train 0x100 to conf 2, then update pc 0x200 (same index 0, different tag) -> lookup 0x100 gives pred_confident=0, pred_value=0.
  - Retrain 0x100 on 0x5, then update value 0x7 -> lookup gives pred_value=0x7, pred_confident=0.
- Same cycle: lookup and update pc 0x100 (trained at 0x5, conf=2) with value 0x9 -> pred_value=0x5, pred_confident=1. Next lookup -> 0x9 (last-value build), pred_confident=0.
- Flush after training 0x100 -> ready=0 for 64 cycles; an update during the sweep is ignored. After ready=1, lookup 0x100 -> pred_confident=0, pred_value=0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// Shared types for the load-value predictor table.
// VP_STRIDE_EN adds a per-entry stride field (last + stride prediction).
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package mips_core_pkg;
    localparam int VP_ADDR_W  = `ADDR_WIDTH;
    localparam int VP_DATA_W  = `DATA_WIDTH;
    localparam int VP_INDEX_W = 6;
    localparam int VP_TAG_W   = VP_ADDR_W - VP_INDEX_W - 2;
    localparam int VP_CONF_W  = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } vp_state_t;

    typedef struct packed {
        logic                 valid;
        logic [VP_TAG_W-1:0]  tag;
        logic [VP_DATA_W-1:0] last;
`ifdef VP_STRIDE_EN
        logic [VP_DATA_W-1:0] stride;
`endif
        logic [VP_CONF_W-1:0] conf;
    } vp_entry_t;

    // Value the entry would predict for the next execution of its load.
    function automatic logic [VP_DATA_W-1:0] vp_predict(input vp_entry_t e);
`ifdef VP_STRIDE_EN
        return e.last + e.stride;
`else
        return e.last;
`endif
    endfunction
endpackage

// File: rtl/vp_conf_counter.sv
// Saturating confidence counter next-value logic; clear wins over increment.
module vp_conf_counter #(
    parameter int CONF_WIDTH = 2
) (
    input  logic [CONF_WIDTH-1:0] conf_i,
    input  logic                  inc_i,
    input  logic                  clr_i,
    output logic [CONF_WIDTH-1:0] conf_o
);
    localparam logic [CONF_WIDTH-1:0] SAT = '1;

    always_comb begin
        conf_o = conf_i;
        if (clr_i)
            conf_o = '0;
        else if (inc_i && conf_i != SAT)
            conf_o = conf_i + 1'b1;
    end
endmodule

// File: rtl/value_predict_table.sv
// PC-indexed direct-mapped load-value predictor with a clear-sweep FSM.
// Build option VP_STRIDE_EN: stride predictor; otherwise last-value predictor.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module value_predict_table
    import mips_core_pkg::*;
#(
    parameter int INDEX_WIDTH = VP_INDEX_W,
    parameter int CONF_WIDTH  = VP_CONF_W,
    parameter int CONF_THRESH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    output logic                   ready,
    input  logic                   lookup_valid,
    input  logic [`ADDR_WIDTH-1:0] lookup_pc,
    output logic                   pred_valid,
    output logic [`DATA_WIDTH-1:0] pred_value,
    output logic                   pred_confident,
    input  logic                   update_valid,
    input  logic [`ADDR_WIDTH-1:0] update_pc,
    input  logic [`DATA_WIDTH-1:0] update_value
);
    localparam int                     ENTRIES  = 1 << INDEX_WIDTH;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(ENTRIES - 1);
    localparam logic [CONF_WIDTH-1:0]  THRESH   = CONF_WIDTH'(CONF_THRESH);

    vp_state_t               state_q, state_d;
    logic [INDEX_WIDTH-1:0]  clr_idx_q, clr_idx_d;
    logic                    ready_q;
    logic                    pred_valid_q;
    logic [`DATA_WIDTH-1:0]  pred_value_q;
    logic                    pred_conf_q;

    // Data array is deliberately unreset; the sweep clears only valid bits.
    vp_entry_t               table_q [ENTRIES];

    logic [INDEX_WIDTH-1:0]  lk_idx, up_idx;
    logic [VP_TAG_W-1:0]     lk_tag, up_tag;
    vp_entry_t               lk_ent, up_ent, up_new;
    logic                    lk_hit, up_hit, up_match, up_en;
    logic [CONF_WIDTH-1:0]   up_conf;
    logic                    unused_pc_lsb;

    assign lk_idx = lookup_pc[INDEX_WIDTH+1:2];
    assign lk_tag = lookup_pc[`ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign up_idx = update_pc[INDEX_WIDTH+1:2];
    assign up_tag = update_pc[`ADDR_WIDTH-1:INDEX_WIDTH+2];
    assign unused_pc_lsb = ^{lookup_pc[1:0], update_pc[1:0]};

    assign lk_ent   = table_q[lk_idx];
    assign lk_hit   = ready_q && lk_ent.valid && (lk_ent.tag == lk_tag);
    assign up_ent   = table_q[up_idx];
    assign up_hit   = up_ent.valid && (up_ent.tag == up_tag);
    assign up_match = (update_value == vp_predict(up_ent));
    assign up_en    = update_valid && !flush && (state_q == IDLE);

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            CLEAR: begin
                if (flush) begin
                    clr_idx_d = '0;
                end else if (clr_idx_q == LAST_IDX) begin
                    state_d   = IDLE;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + 1'b1;
                end
            end
            IDLE: begin
                if (flush) begin
                    state_d   = CLEAR;
                    clr_idx_d = '0;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    vp_conf_counter #(
        .CONF_WIDTH(CONF_WIDTH)
    ) u_conf (
        .conf_i (up_ent.conf),
        .inc_i  (up_match),
        .clr_i  (!up_match),
        .conf_o (up_conf)
    );

    always_comb begin
        up_new       = up_ent;
        up_new.valid = 1'b1;
        up_new.tag   = up_tag;
        up_new.last  = update_value;
        if (up_hit) begin
            up_new.conf   = up_conf;
`ifdef VP_STRIDE_EN
            up_new.stride = update_value - up_ent.last;
`endif
        end else begin
            up_new.conf   = '0;
`ifdef VP_STRIDE_EN
            up_new.stride = '0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == CLEAR)
            table_q[clr_idx_q].valid <= 1'b0;
        else if (up_en)
            table_q[up_idx] <= up_new;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= CLEAR;
            clr_idx_q    <= '0;
            ready_q      <= 1'b0;
            pred_valid_q <= 1'b0;
            pred_value_q <= '0;
            pred_conf_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            ready_q      <= (state_d == IDLE);
            pred_valid_q <= lookup_valid;
            pred_value_q <= (lookup_valid && lk_hit) ? vp_predict(lk_ent) : '0;
            pred_conf_q  <= lookup_valid && lk_hit && (lk_ent.conf >= THRESH);
        end
    end

    assign ready          = ready_q;
    assign pred_valid     = pred_valid_q;
    assign pred_value     = pred_value_q;
    assign pred_confident = pred_conf_q;
endmodule

// File: tb/tb_value_predict_table.sv
// Scoreboard bench for value_predict_table; expectations follow VP_STRIDE_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_value_predict_table;
`ifdef VP_STRIDE_EN
    localparam bit STR = 1'b1;
`else
    localparam bit STR = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   flush = 1'b0;
    logic                   ready;
    logic                   lookup_valid = 1'b0;
    logic [`ADDR_WIDTH-1:0] lookup_pc = '0;
    logic                   pred_valid;
    logic [`DATA_WIDTH-1:0] pred_value;
    logic                   pred_confident;
    logic                   update_valid = 1'b0;
    logic [`ADDR_WIDTH-1:0] update_pc = '0;
    logic [`DATA_WIDTH-1:0] update_value = '0;

    typedef struct {
        logic [`DATA_WIDTH-1:0] v;
        logic                   c;
    } exp_t;

    exp_t  sbq[$];
    int    n_chk  = 0;
    int    n_pass = 0;
    string phase  = "reset";

    always #5 clk = ~clk;

    value_predict_table dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .ready          (ready),
        .lookup_valid   (lookup_valid),
        .lookup_pc      (lookup_pc),
        .pred_valid     (pred_valid),
        .pred_value     (pred_value),
        .pred_confident (pred_confident),
        .update_valid   (update_valid),
        .update_pc      (update_pc),
        .update_value   (update_value)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s [%s]: got %0h, expected %0h", tag, phase, obs, exp);
        else
            n_pass++;
    endtask

    // Predictions are compared in order against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (pred_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_pred", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("pred_value", pred_value, e.v);
                chk("pred_conf", pred_confident, e.c);
            end
        end else begin
            chk("idle_zero", {pred_value, pred_confident}, 0);
        end
    end

    task automatic push_exp(input logic [`DATA_WIDTH-1:0] v, input logic c);
        exp_t e;
        e.v = v;
        e.c = c;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        update_valid = 1'b0;
    endtask

    task automatic upd(input logic [`ADDR_WIDTH-1:0] pc, input logic [`DATA_WIDTH-1:0] val);
        update_valid = 1'b1;
        update_pc    = pc;
        update_value = val;
        step();
    endtask

    task automatic look(input logic [`ADDR_WIDTH-1:0] pc, input logic [`DATA_WIDTH-1:0] v, input logic c);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        push_exp(v, c);
        step();
        step();
    endtask

    initial begin
        int cnt;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready, 0);
        chk("rst_pred_valid", pred_valid, 0);
        chk("rst_pred_value", pred_value, 0);
        chk("rst_pred_conf", pred_confident, 0);

        @(posedge clk);
        #1 rst_n = 1'b0;
        phase = "init_sweep";
        cnt = 0;
        while (!ready && cnt < 200) begin
            step();
            cnt++;
        end
        chk("sweep_cycles", cnt, 64);

        phase = "cold_lookup";
        look(32'h100, 0, 0);

        phase = "last_value";
        repeat (3) upd(32'h100, 32'h5);
        look(32'h100, 32'h5, 1);

        phase = "stride";
        upd(32'h104, 10);
        upd(32'h104, 20);
        upd(32'h104, 30);
        upd(32'h104, 40);
        look(32'h104, STR ? 50 : 40, STR);

        phase = "conflict";
        upd(32'h200, 32'h1);
        look(32'h100, 0, 0);

        phase = "mispredict";
        upd(32'h100, 32'h5);
        upd(32'h100, 32'h7);
        look(32'h100, STR ? 32'h9 : 32'h7, 0);

        phase = "same_cycle";
        upd(32'h200, 32'h1);
        repeat (3) upd(32'h100, 32'h5);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h100;
        update_valid = 1'b1;
        update_pc    = 32'h100;
        update_value = 32'h9;
        push_exp(32'h5, 1);
        step();
        step();
        look(32'h100, STR ? 32'hd : 32'h9, 0);

        phase = "flush";
        upd(32'h200, 32'h1);
        repeat (3) upd(32'h100, 32'h5);
        look(32'h100, 32'h5, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ready_drop", ready, 0);
        cnt = 0;
        while (!ready && cnt < 200) begin
            if (cnt == 10) begin
                update_valid = 1'b1;
                update_pc    = 32'h100;
                update_value = 32'h5;
            end else if (cnt == 20) begin
                lookup_valid = 1'b1;
                lookup_pc    = 32'h100;
                push_exp(0, 0);
            end
            step();
            cnt++;
        end
        chk("flush_sweep_cycles", cnt, 64);
        phase = "post_flush";
        look(32'h100, 0, 0);

        step();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
